// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types, default widths and saturation-bound helpers for
// the neuron datapath (MAC stage now, bias adder later).
//   mac_state_t      : MAC controller states
//   IN_W_DEF/ACC_W_DEF/PROD_W_DEF : default operand, accumulator, product widths
//   sat_max/sat_min  : largest/smallest value of a signed field of given width
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

  localparam int IN_W_DEF   = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int PROD_W_DEF = 2 * IN_W_DEF;

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// neuron_mac_if: pair-stream and result bus of the MAC stage.
//   start, x_valid, x_data, w_data : driven by the producer (master)
//   x_ready, acc_out, acc_valid, busy, overflow : driven by the MAC (slave)
interface neuron_mac_if
  import neuron_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
);
  logic                    start;
  logic                    x_valid;
  logic                    x_ready;
  logic signed [IN_W-1:0]  x_data;
  logic signed [IN_W-1:0]  w_data;
  logic signed [ACC_W-1:0] acc_out;
  logic                    acc_valid;
  logic                    busy;
  logic                    overflow;

  modport master (
    output start, x_valid, x_data, w_data,
    input  x_ready, acc_out, acc_valid, busy, overflow
  );

  modport slave (
    input  start, x_valid, x_data, w_data,
    output x_ready, acc_out, acc_valid, busy, overflow
  );
endinterface

// File: rtl/neuron_sat_add.sv
// neuron_sat_add: combinational saturating add of a signed accumulator and a
// signed addend (product or bias).
//   acc_i  : ACC_W signed running value
//   prod_i : PROD_W signed addend
//   sum_o  : ACC_W signed result, clamped to the ACC_W range
//   sat_o  : high when the clamp was applied
module neuron_sat_add
  import neuron_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int PROD_W = PROD_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [ACC_W-1:0]  sum_o,
  output logic                     sat_o
);
  // One guard bit above the wider operand, so the true sum never wraps.
  localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(sat_max(ACC_W));
  localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(sat_min(ACC_W));

  logic signed [SUM_W-1:0] sum_w;

  always_comb begin
    sum_w = SUM_W'(acc_i) + SUM_W'(prod_i);
    sum_o = sum_w[ACC_W-1:0];
    sat_o = 1'b0;
    if (sum_w > MAX_V) begin
      sum_o = MAX_V[ACC_W-1:0];
      sat_o = 1'b1;
    end else if (sum_w < MIN_V) begin
      sum_o = MIN_V[ACC_W-1:0];
      sat_o = 1'b1;
    end
  end
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: sequential multiply-accumulate feeding the neuron bias adder.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : neuron_mac_if slave -- start, x/w pair stream (valid/ready),
//                acc_out, acc_valid pulse, busy, sticky overflow
// Stage 1 registers the full-width product of each accepted pair; stage 2
// folds the registered product into the saturating accumulator on the next
// edge, whatever the state. DRAIN exists so the last product lands before
// DONE presents the result.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int IN_W     = IN_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  neuron_mac_if.slave bus
);
  localparam int PROD_W = 2 * IN_W;
  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  mac_state_t               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     prod_v_q, prod_v_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;

  logic signed [ACC_W-1:0]  sum_sat;
  logic                     sum_clamped;
  logic                     accept;

  neuron_sat_add #(
    .ACC_W (ACC_W),
    .PROD_W(PROD_W)
  ) u_sat_add (
    .acc_i (acc_q),
    .prod_i(prod_q),
    .sum_o (sum_sat),
    .sat_o (sum_clamped)
  );

  assign accept = (state_q == ACCUM) && bus.x_valid;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    prod_v_d = 1'b0;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (prod_v_q) begin
      acc_d = sum_sat;
      if (sum_clamped) ovf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // prod_v is always 0 here, so clearing cannot drop a product.
        if (bus.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          prod_d   = PROD_W'(bus.x_data) * PROD_W'(bus.w_data);
          prod_v_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.x_ready   = (state_q == ACCUM);
  assign bus.busy      = (state_q != IDLE);
  assign bus.acc_valid = (state_q == DONE);
  assign bus.acc_out   = acc_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: drives a 4-input and a 1-input neuron_mac with directed and
// random operations and compares against a plain-arithmetic dot-product model.
module tb_neuron_mac;
  import neuron_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_mac_if #(.IN_W(8), .ACC_W(16)) bus4 ();
  neuron_mac_if #(.IN_W(8), .ACC_W(16)) bus1 ();

  neuron_mac #(.N_INPUTS(4), .IN_W(8), .ACC_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );
  neuron_mac #(.N_INPUTS(1), .IN_W(8), .ACC_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  int xq[$];
  int wq[$];
  bit vpat[$];

  task automatic check_val(input string tag, input logic signed [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Dot product of xq.wq with the accumulator clamped to 16-bit range after
  // every term; ovf reports whether any clamp occurred.
  function automatic void model_dot(output int acc, output int ovf);
    acc = 0;
    ovf = 0;
    foreach (xq[i]) begin
      acc = acc + xq[i] * wq[i];
      if (acc > 32767) begin
        acc = 32767;
        ovf = 1;
      end else if (acc < -32768) begin
        acc = -32768;
        ovf = 1;
      end
    end
  endfunction

  function automatic int rand_val();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return 127;
    if (r == 1) return -128;
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // One full operation on the 4-input DUT, entered in an IDLE cycle.
  // vpat gives x_valid for successive ACCUM cycles (1 once exhausted).
  // poke_start pulses start mid-stream and again in the acc_valid cycle.
  task automatic do_op(input string tag, input bit poke_start);
    int exp_acc, exp_ovf, idx, cyc, pulses;
    bit v;
    model_dot(exp_acc, exp_ovf);
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    check_val({tag, ".busy_start"}, bus4.busy, 1);
    idx = 0;
    cyc = 0;
    pulses = 0;
    while (idx < xq.size() && cyc < 100) begin
      v = (cyc < vpat.size()) ? vpat[cyc] : 1'b1;
      check_val({tag, ".x_ready"}, bus4.x_ready, 1);
      bus4.x_valid = v;
      bus4.x_data  = 8'(xq[idx]);
      bus4.w_data  = 8'(wq[idx]);
      bus4.start   = poke_start && (cyc == 1);
      @(posedge clk); #1;
      if (bus4.acc_valid) pulses++;
      if (v) idx++;
      cyc++;
    end
    bus4.x_valid = 1'b0;
    bus4.start   = 1'b0;
    check_val({tag, ".accepted"}, idx, xq.size());
    check_val({tag, ".drain_ready"}, bus4.x_ready, 0);
    check_val({tag, ".early_valid"}, pulses, 0);
    @(posedge clk); #1;
    bus4.start = poke_start;
    check_val({tag, ".acc_valid"}, bus4.acc_valid, 1);
    check_val({tag, ".acc_out"}, bus4.acc_out, exp_acc);
    check_val({tag, ".overflow"}, bus4.overflow, exp_ovf);
    $display("op %s: expected acc=%0d ovf=%0d, observed acc=%0d ovf=%0d",
             tag, exp_acc, exp_ovf, bus4.acc_out, bus4.overflow);
    @(posedge clk); #1;
    bus4.start = 1'b0;
    check_val({tag, ".busy_after"}, bus4.busy, 0);
    check_val({tag, ".valid_after"}, bus4.acc_valid, 0);
    check_val({tag, ".acc_hold"}, bus4.acc_out, exp_acc);
  endtask

  task automatic do_op1(input string tag);
    int exp_acc, exp_ovf;
    model_dot(exp_acc, exp_ovf);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    check_val({tag, ".x_ready"}, bus1.x_ready, 1);
    bus1.x_valid = 1'b1;
    bus1.x_data  = 8'(xq[0]);
    bus1.w_data  = 8'(wq[0]);
    @(posedge clk); #1;
    bus1.x_valid = 1'b0;
    check_val({tag, ".drain_ready"}, bus1.x_ready, 0);
    check_val({tag, ".early_valid"}, bus1.acc_valid, 0);
    @(posedge clk); #1;
    check_val({tag, ".acc_valid"}, bus1.acc_valid, 1);
    check_val({tag, ".acc_out"}, bus1.acc_out, exp_acc);
    check_val({tag, ".overflow"}, bus1.overflow, exp_ovf);
    $display("op %s: expected acc=%0d ovf=%0d, observed acc=%0d ovf=%0d",
             tag, exp_acc, exp_ovf, bus1.acc_out, bus1.overflow);
    @(posedge clk); #1;
    check_val({tag, ".busy_after"}, bus1.busy, 0);
  endtask

  initial begin
    bus4.start = 1'b0; bus4.x_valid = 1'b0; bus4.x_data = '0; bus4.w_data = '0;
    bus1.start = 1'b0; bus1.x_valid = 1'b0; bus1.x_data = '0; bus1.w_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.acc_out", bus4.acc_out, 0);
    check_val("rst.busy", bus4.busy, 0);
    check_val("rst.x_ready", bus4.x_ready, 0);
    check_val("rst.overflow", bus4.overflow, 0);
    check_val("rst.acc_valid", bus4.acc_valid, 0);
    check_val("rst.acc_out1", bus1.acc_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vpat.delete();
    xq = '{1, 2, 3, 4};          wq = '{5, 6, 7, 8};          do_op("basic", 1'b0);
    xq = '{127, 127, 127, 127};  wq = '{127, 127, 127, 127};  do_op("pos_sat", 1'b0);
    xq = '{-128, -128, -128, -128}; wq = '{-128, -128, -128, -128}; do_op("pos_sat_neg", 1'b0);
    xq = '{-128, -128, -128, 127}; wq = '{127, 127, 127, 127}; do_op("neg_sat_recover", 1'b0);
    vpat = '{1, 0, 0, 1, 1, 0, 1};
    xq = '{2, -3, 4, -5};        wq = '{10, 10, 10, 10};      do_op("bubbles", 1'b1);
    vpat.delete();

    // Reset in the middle of an operation.
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    bus4.x_valid = 1'b1; bus4.x_data = 8'sd127; bus4.w_data = 8'sd127;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus4.x_valid = 1'b0;
    @(posedge clk); #1;
    check_val("midrst.pre_acc", bus4.acc_out, 32258);
    rst_n = 1'b0;
    #1;
    check_val("midrst.acc_out", bus4.acc_out, 0);
    check_val("midrst.busy", bus4.busy, 0);
    check_val("midrst.x_ready", bus4.x_ready, 0);
    check_val("midrst.overflow", bus4.overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xq = '{1, 1, 1, 1}; wq = '{1, 1, 1, 1}; do_op("after_rst", 1'b0);

    // Back-to-back random operations with random bubbles.
    for (int t = 0; t < 20; t++) begin
      xq.delete(); wq.delete(); vpat.delete();
      for (int k = 0; k < 4; k++) begin
        xq.push_back(rand_val());
        wq.push_back(rand_val());
      end
      for (int k = 0; k < int'($urandom_range(0, 6)); k++)
        vpat.push_back(1'($urandom_range(0, 1)));
      do_op($sformatf("rand%0d", t), 1'($urandom_range(0, 1)));
    end
    vpat.delete();

    // Single-input configuration.
    xq = '{-7}; wq = '{9}; do_op1("n1_basic");
    for (int t = 0; t < 4; t++) begin
      xq = '{rand_val()}; wq = '{rand_val()};
      do_op1($sformatf("n1_rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Sequential multiply-accumulate stage directly upstream of the neuron bias adder.
- Streams N_INPUTS signed (x, w) pairs through a valid/ready handshake and forms the saturated 16-bit dot product.
- Its acc_out drives the adder's 16-bit in1 port; acc_valid marks the one cycle in which the result is final.

Parameters:
N_INPUTS, 4, number of (x, w) pairs per dot product; legal range 1..255
IN_W, 8, width of signed x_data and w_data
ACC_W, 16, width of signed accumulator and acc_out

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request to begin a new dot product
x_valid  input  1  x_data/w_data pair valid
x_ready  output  1  block accepts a pair this cycle
x_data  input  IN_W  signed activation input
w_data  input  IN_W  signed weight
acc_out  output  ACC_W  signed saturated dot product
acc_valid  output  1  one-cycle pulse: acc_out is final
busy  output  1  operation in progress (state != IDLE)
overflow  output  1  sticky: saturation occurred in the current operation

Behaviour:
- Reset: asynchronous, active-low. State goes to IDLE. Accumulator, product register, product-valid flag, count, overflow and acc_valid all reset to 0, so x_ready=0 and busy=0. A reset mid-operation aborts the operation and leaves no partial result.
- FSM states: IDLE, ACCUM, DRAIN, DONE. All outputs are decoded from registered state, so none are glitchy.
- IDLE: x_ready=0, busy=0.
  - start=1 clears the accumulator, count and overflow, then moves to ACCUM.
  - x_valid is ignored.
  - acc_out holds the previous result until start clears it.
- ACCUM: x_ready=1.
  - A pair is accepted when x_valid && x_ready at a clock edge.
  - On acceptance: prod_r <= x_data * w_data, a full 2*IN_W signed product with no truncation; prod_v <= 1; count++.
  - Cycles with x_valid=0 are bubbles: no count change and prod_v <= 0.
  - On acceptance of pair number N_INPUTS, move to DRAIN.
- Stage 2 runs in every state: when prod_v=1, acc <= sat(acc + sext(prod_r)).
  - The sum is computed at ACC_W+1 bits.
  - If the sum is above 2^(ACC_W-1)-1, acc takes that maximum and overflow <= 1.
  - If the sum is below -2^(ACC_W-1), acc takes that minimum and overflow <= 1.
  - Saturation is applied per step; a later opposite-sign term can pull acc back off the rail, but overflow stays set.
- DRAIN: x_ready=0. The last product accumulates in this cycle; next state is DONE.
- DONE: acc_valid=1 for exactly one cycle, then IDLE. acc_out equals the final accumulator.
- Latency: from the clock edge that accepts the last pair, acc_valid is high in the second following cycle (edge+2).
- With no bubbles, throughput is N_INPUTS+3 cycles per operation, counted from start to the return to IDLE.
- start is ignored in ACCUM, DRAIN and DONE, including start asserted in the same cycle as acc_valid.
- N_INPUTS=1: ACCUM lasts until the first accepted pair, then DRAIN.
- Count width is $clog2(N_INPUTS+1); the count never wraps.
- acc_out = acc register in all states.
- busy = (state != IDLE).

Decomposition:
- Package neuron_pkg holds:
  - state typedef mac_state_t {IDLE, ACCUM, DRAIN, DONE};
  - localparams for default IN_W/ACC_W and the derived PROD_W = 2*IN_W;
  - a saturation-bound function sat_max/sat_min(width).
- One sub-module, neuron_sat_add: combinational, ACC_W signed acc plus PROD_W signed product gives a saturated ACC_W result plus a sat flag. It is reusable by the bias adder later.
- The FSM and the two register stages live in neuron_mac.

Test Plan:
- Basic dot product: start, then x=[1,2,3,4], w=[5,6,7,8] with x_valid held high. Required: acc_out=70, acc_valid one cycle at edge+2 after the 4th accept, overflow=0, busy falls the cycle after.
- Positive saturation: x=w=127 for all 4 pairs (4*16129=64516). Required: acc_out=32767, overflow=1. Then x=w=-128 repeated (4*16384=65536) → acc_out=32767, overflow=1.
- Negative saturation and recovery: x=-128, w=127 for 3 pairs, then x=127, w=127. Required: acc clamps at -32768 after pair 3, final acc_out=-32768+16129=-16639, overflow=1.
- Bubbles and start-while-busy: x_valid toggled 1,0,0,1,1,0,1 with x=[2,-3,4,-5], w=[10,10,10,10] and a start pulse mid-stream. Required: acc_out=-20, the start is ignored, and acc_valid occurs exactly once.
- Reset mid-operation: assert rst_n=0 after 2 accepted pairs. Required: acc_out=0, busy=0, x_ready=0, overflow=0 immediately. A following start with [1,1,1,1]·[1,1,1,1] gives 4.
- Back-to-back and N_INPUTS=1: start is asserted in the IDLE cycle right after acc_valid; the second result must not include the first. Separately, at N_INPUTS=1, x=-7, w=9 gives acc_out=-63.
